// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read.
//   Stores DATA_DEPTH words of DATA_WIDTH bits. The head word is visible on
//   rd_data_o before the edge that pops it, so the consumer takes
//   rd_data_o and rd_data_vaild_o at the same edge that issues the pop.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_en_i          push request; ignored while full (even when popping too)
//   wr_data_i        push data
//   rd_en_i          pop request; ignored while empty (no write bypass)
//   rd_data_vaild_o  rd_en_i & ~empty_o (this pop will be serviced)
//   rd_data_o        head word, 0 when empty
//   elem_cnt_o       occupancy 0..DATA_DEPTH
//   full_o, empty_o  occupancy flags, derived from registered state
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en_i,
  input  logic [DATA_WIDTH-1:0]         wr_data_i,
  input  logic                          rd_en_i,
  output logic                          rd_data_vaild_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DATA_DEPTH):0]   elem_cnt_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_CNT = PW'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count;
  logic                  wr_acc;
  logic                  rd_acc;

  // Pointers carry one extra wrap bit, so their difference is the
  // occupancy over the full 0..DATA_DEPTH range.
  always_comb begin
    count           = wr_ptr - rd_ptr;
    full_o          = (count == DEPTH_CNT);
    empty_o         = (count == '0);
    elem_cnt_o      = count;
    wr_acc          = wr_en_i && !full_o;
    rd_acc          = rd_en_i && !empty_o;
    rd_data_vaild_o = rd_acc;
    rd_data_o       = empty_o ? '0 : mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en_i;
  logic [DW-1:0] wr_data_i;
  logic          rd_en_i;
  logic          rd_data_vaild_o;
  logic [DW-1:0] rd_data_o;
  logic [3:0]    elem_cnt_o;
  logic          full_o;
  logic          empty_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference: plain queue of stored words.
  logic [DW-1:0] q[$];

  sync_fifo #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en_i         (wr_en_i),
    .wr_data_i       (wr_data_i),
    .rd_en_i         (rd_en_i),
    .rd_data_vaild_o (rd_data_vaild_o),
    .rd_data_o       (rd_data_o),
    .elem_cnt_o      (elem_cnt_o),
    .full_o          (full_o),
    .empty_o         (empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp_v, exp_v, $time);
    end
  endtask

  task automatic check_outputs(input logic rd);
    logic [31:0] head;
    head = (q.size() > 0) ? q[0] : 32'd0;
    check("vld",   32'(rd_data_vaild_o), 32'(rd && (q.size() > 0)));
    check("rdata", rd_data_o, head);
    check("cnt",   32'(elem_cnt_o), 32'(q.size()));
    check("full",  32'(full_o), 32'(q.size() == DEPTH));
    check("empty", 32'(empty_o), 32'(q.size() == 0));
  endtask

  // One clock cycle: drive at negedge, check pre-edge outputs, apply the
  // FIFO rules to the model at the posedge.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd);
    bit w_ok, r_ok;
    @(negedge clk);
    wr_en_i = wr; wr_data_i = d; rd_en_i = rd;
    #1;
    check_outputs(rd);
    w_ok = wr && (q.size() < DEPTH);
    r_ok = rd && (q.size() > 0);
    @(posedge clk);
    if (r_ok) void'(q.pop_front());
    if (w_ok) q.push_back(d);
  endtask

  initial begin
    rst_n = 1'b0; wr_en_i = 1'b0; wr_data_i = '0; rd_en_i = 1'b0;
    repeat (2) @(negedge clk);
    rd_en_i = 1'b1;
    #1;
    check("rst_vld",   32'(rd_data_vaild_o), 32'd0);
    check("rst_rdata", rd_data_o, 32'd0);
    check("rst_cnt",   32'(elem_cnt_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full",  32'(full_o), 32'd0);
    rd_en_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: pops on empty FIFO are ignored
    repeat (4) step(1'b0, '0, 1'b1);
    // 2: writes 5..14, 13 and 14 dropped
    for (int i = 5; i <= 14; i++) step(1'b1, DW'(i), 1'b0);
    step(1'b0, '0, 1'b0);
    check("s2_cnt", 32'(elem_cnt_o), 32'd8);
    // 3: three pops -> 5,6,7
    for (int i = 5; i <= 7; i++) begin
      step(1'b0, '0, 1'b1);
    end
    step(1'b0, '0, 1'b0);
    check("s3_cnt", 32'(elem_cnt_o), 32'd5);
    // 4: simultaneous push/pop, write pointer wraps
    step(1'b1, DW'(23), 1'b1);
    step(1'b1, DW'(45), 1'b1);
    step(1'b0, '0, 1'b0);
    check("s4_cnt",  32'(elem_cnt_o), 32'd5);
    check("s4_head", rd_data_o, 32'd10);
    // 5: seven pops, last two ignored
    repeat (7) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check("s5_empty", 32'(empty_o), 32'd1);

    // Write on empty with a simultaneous read: no bypass
    step(1'b1, DW'(77), 1'b1);
    step(1'b0, '0, 1'b0);
    check("nobyp_cnt", 32'(elem_cnt_o), 32'd1);
    step(1'b0, '0, 1'b1);
    // Fill, then push+pop while full: push dropped
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(100 + i), 1'b0);
    step(1'b1, DW'(999), 1'b1);
    step(1'b0, '0, 1'b0);
    check("fullrw_cnt", 32'(elem_cnt_o), 32'(DEPTH - 1));
    repeat (DEPTH) step(1'b0, '0, 1'b1);

    // 6: asynchronous reset with 3 entries stored
    for (int i = 0; i < 3; i++) step(1'b1, DW'(200 + i), 1'b0);
    @(negedge clk);
    wr_en_i = 1'b0; rd_en_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_empty", 32'(empty_o), 32'd1);
    check("arst_cnt",   32'(elem_cnt_o), 32'd0);
    check("arst_rdata", rd_data_o, 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, DW'(32'hCAFE), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      int unsigned bias;
      bias = (n / 100) % 2 == 0 ? 70 : 30;
      step(($urandom_range(99) < bias), $urandom, ($urandom_range(99) >= bias - 10));
    end
    step(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
